// File: rtl/lenet_fc_pkg.sv
// Shared constants for the LeNet fully-connected layers:
// FSM state encoding, MAC pipeline latency and per-layer IFM depths.
package lenet_fc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_WAIT_NEXT = 3'd3,
    ST_HANDOFF   = 3'd4,
    ST_START     = 3'd5
  } fc_state_e;

  localparam int MAC_LATENCY_DEF = 3;
  localparam int FC1_IFM_DEPTH   = 120;
  localparam int FC2_IFM_DEPTH   = 84;

endpackage

// File: rtl/fc_step_counter.sv
// Step counter shared by the RUN and DRAIN phases.
// Ports: clk_i, reset_i (sync, high), en_i, clr_i, last_i (terminal value),
//        count_o (current count), tc_o (enabled and at terminal value).
module fc_step_counter #(
  parameter int W = 7
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc_o    = en_i && (cnt_q == last_i);
  assign count_o = cnt_q;

  // Wraps to zero on terminal count so the next phase starts clean.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = tc_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fc_layer_seq_ctrl.sv
// Sequencer for one fully-connected layer: takes the IFM buffer, streams
// IFM_DEPTH read addresses, drains the MAC pipeline and hands results on.
// Ports: clk, reset (sync, high); previous-layer handshake start_from_previous /
//   end_to_previous; datapath controls ifm_sel, enable_read_fc, wm_addr_sel,
//   wm_address_read_current, wm_enable_read, bias_sel, acc_enable;
//   next-layer handshake ifm_enable_write_next, start_to_next, end_from_next;
//   busy (not IDLE).
module fc_layer_seq_ctrl
  import lenet_fc_pkg::*;
#(
  parameter int ADDRESS_BITS = 11,
  parameter int IFM_DEPTH    = FC1_IFM_DEPTH,
  parameter int MAC_LATENCY  = MAC_LATENCY_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_from_previous,
  output logic                    end_to_previous,
  output logic                    ifm_sel,
  output logic                    enable_read_fc,
  output logic                    wm_addr_sel,
  output logic [ADDRESS_BITS-1:0] wm_address_read_current,
  output logic                    wm_enable_read,
  output logic                    bias_sel,
  output logic                    acc_enable,
  output logic                    ifm_enable_write_next,
  output logic                    start_to_next,
  input  logic                    end_from_next,
  output logic                    busy
);

  localparam int CNT_MAX =
    (IFM_DEPTH > MAC_LATENCY) ? IFM_DEPTH : MAC_LATENCY;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(IFM_DEPTH - 1);
  localparam logic [CW-1:0] DRN_LAST = CW'(MAC_LATENCY - 1);

  fc_state_e state_q, state_d;
  logic      pend_q, pend_d;
  logic      nbusy_q, nbusy_d;
  logic      acc_q;

  logic          cnt_en;
  logic          cnt_clr;
  logic          cnt_tc;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_last;

  fc_step_counter #(
    .W(CW)
  ) u_cnt (
    .clk_i  (clk),
    .reset_i(reset),
    .en_i   (cnt_en),
    .clr_i  (cnt_clr),
    .last_i (cnt_last),
    .count_o(cnt),
    .tc_o   (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    nbusy_d  = end_from_next ? 1'b0 : nbusy_q;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b1;
    cnt_last = RUN_LAST;

    end_to_previous         = 1'b0;
    ifm_sel                 = 1'b0;
    enable_read_fc          = 1'b0;
    wm_addr_sel             = 1'b0;
    wm_address_read_current = '0;
    wm_enable_read          = 1'b0;
    bias_sel                = 1'b0;
    ifm_enable_write_next   = 1'b0;
    start_to_next           = 1'b0;

    // Only one start is remembered while the layer is occupied.
    if (start_from_previous && state_q != ST_IDLE)
      pend_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (start_from_previous || pend_q) begin
          state_d = ST_RUN;
          pend_d  = 1'b0;
        end
      end
      ST_RUN: begin
        cnt_en                  = 1'b1;
        cnt_clr                 = 1'b0;
        ifm_sel                 = 1'b1;
        enable_read_fc          = 1'b1;
        wm_addr_sel             = 1'b1;
        wm_enable_read          = 1'b1;
        wm_address_read_current = ADDRESS_BITS'(cnt);
        bias_sel                = (cnt == '0);
        if (cnt_tc)
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        cnt_en          = 1'b1;
        cnt_clr         = 1'b0;
        cnt_last        = DRN_LAST;
        end_to_previous = (cnt == '0);
        if (cnt_tc)
          state_d = ST_WAIT_NEXT;
      end
      ST_WAIT_NEXT: begin
        if (!nbusy_q || end_from_next)
          state_d = ST_HANDOFF;
      end
      ST_HANDOFF: begin
        ifm_enable_write_next = 1'b1;
        state_d               = ST_START;
      end
      ST_START: begin
        start_to_next = 1'b1;
        nbusy_d       = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign acc_enable = acc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      nbusy_q <= 1'b0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      nbusy_q <= nbusy_d;
      acc_q   <= wm_enable_read;
    end
  end

endmodule

// File: tb/tb_fc_layer_seq_ctrl.sv
// Self-checking bench for fc_layer_seq_ctrl (FC1 defaults and an
// FC2-sized instance with MAC_LATENCY=1).
module tb_fc_layer_seq_ctrl;
  import lenet_fc_pkg::*;

  localparam int AB = 11;

  logic clk = 1'b0;
  logic reset;
  logic sfp0, efn0, sfp1, efn1;

  logic etp0, ifs0, rdf0, wms0, wmr0, bias0, acc0, iwn0, stn0, busy0;
  logic [AB-1:0] addr0;
  logic etp1, ifs1, rdf1, wms1, wmr1, bias1, acc1, iwn1, stn1, busy1;
  logic [AB-1:0] addr1;

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic          ifm_sel;
    logic          rd_fc;
    logic          wm_sel;
    logic          wm_rd;
    logic          bias;
    logic          acc;
    logic          etp;
    logic          iwn;
    logic          stn;
    logic          busy;
    logic [AB-1:0] addr;
  } out_t;

  typedef struct {
    logic  sfp;
    logic  efn;
    out_t  exp;
    string nm;
  } vec_t;

  out_t o0, o1;
  vec_t tail[7];

  assign o0 = {ifs0, rdf0, wms0, wmr0, bias0, acc0,
               etp0, iwn0, stn0, busy0, addr0};
  assign o1 = {ifs1, rdf1, wms1, wmr1, bias1, acc1,
               etp1, iwn1, stn1, busy1, addr1};

  fc_layer_seq_ctrl u0 (
    .clk                    (clk),
    .reset                  (reset),
    .start_from_previous    (sfp0),
    .end_to_previous        (etp0),
    .ifm_sel                (ifs0),
    .enable_read_fc         (rdf0),
    .wm_addr_sel            (wms0),
    .wm_address_read_current(addr0),
    .wm_enable_read         (wmr0),
    .bias_sel               (bias0),
    .acc_enable             (acc0),
    .ifm_enable_write_next  (iwn0),
    .start_to_next          (stn0),
    .end_from_next          (efn0),
    .busy                   (busy0)
  );

  fc_layer_seq_ctrl #(
    .ADDRESS_BITS(AB),
    .IFM_DEPTH   (FC2_IFM_DEPTH),
    .MAC_LATENCY (1)
  ) u1 (
    .clk                    (clk),
    .reset                  (reset),
    .start_from_previous    (sfp1),
    .end_to_previous        (etp1),
    .ifm_sel                (ifs1),
    .enable_read_fc         (rdf1),
    .wm_addr_sel            (wms1),
    .wm_address_read_current(addr1),
    .wm_enable_read         (wmr1),
    .bias_sel               (bias1),
    .acc_enable             (acc1),
    .ifm_enable_write_next  (iwn1),
    .start_to_next          (stn1),
    .end_from_next          (efn1),
    .busy                   (busy1)
  );

  function automatic out_t mk_run(int a);
    out_t o = '0;
    o.ifm_sel = 1'b1;
    o.rd_fc   = 1'b1;
    o.wm_sel  = 1'b1;
    o.wm_rd   = 1'b1;
    o.bias    = (a == 0);
    o.acc     = (a != 0);
    o.busy    = 1'b1;
    o.addr    = AB'(a);
    return o;
  endfunction

  function automatic out_t mk_st(bit acc, bit etp, bit iwn,
                                 bit stn, bit bsy);
    out_t o = '0;
    o.acc  = acc;
    o.etp  = etp;
    o.iwn  = iwn;
    o.stn  = stn;
    o.busy = bsy;
    return o;
  endfunction

  task automatic chk(input string nm, input out_t act, input out_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick0();
    sfp0 = 1'b1;
    step();
    sfp0 = 1'b0;
  endtask

  task automatic run_loop(input int p1, input int p2, input string tag);
    for (int a = 0; a < FC1_IFM_DEPTH; a++) begin
      chk($sformatf("%s_run%0d", tag, a), o0, mk_run(a));
      sfp0 = (a == p1 || a == p2);
      step();
      sfp0 = 1'b0;
    end
  endtask

  task automatic drain_tail(input int stall, input bit end_at_start,
                            input string tag);
    chk({tag, "_drain0"}, o0, mk_st(1, 1, 0, 0, 1));
    step();
    chk({tag, "_drain1"}, o0, mk_st(0, 0, 0, 0, 1));
    step();
    chk({tag, "_drain2"}, o0, mk_st(0, 0, 0, 0, 1));
    step();
    chk({tag, "_wait"}, o0, mk_st(0, 0, 0, 0, 1));
    for (int s = 1; s < stall; s++) begin
      step();
      chk($sformatf("%s_stall%0d", tag, s), o0, mk_st(0, 0, 0, 0, 1));
    end
    efn0 = (stall > 0);
    step();
    efn0 = 1'b0;
    chk({tag, "_handoff"}, o0, mk_st(0, 0, 1, 0, 1));
    efn0 = end_at_start;
    step();
    efn0 = 1'b0;
    chk({tag, "_start"}, o0, mk_st(0, 0, 0, 1, 1));
    step();
    chk({tag, "_idle"}, o0, '0);
  endtask

  initial begin
    tail[0] = '{1'b0, 1'b0, mk_st(1, 1, 0, 0, 1), "t2_drain0"};
    tail[1] = '{1'b0, 1'b0, mk_st(0, 0, 0, 0, 1), "t2_drain1"};
    tail[2] = '{1'b0, 1'b0, mk_st(0, 0, 0, 0, 1), "t2_drain2"};
    tail[3] = '{1'b0, 1'b0, mk_st(0, 0, 0, 0, 1), "t2_wait"};
    tail[4] = '{1'b0, 1'b0, mk_st(0, 0, 1, 0, 1), "t2_handoff"};
    tail[5] = '{1'b0, 1'b0, mk_st(0, 0, 0, 1, 1), "t2_start"};
    tail[6] = '{1'b0, 1'b0, mk_st(0, 0, 0, 0, 0), "t2_idle"};

    reset = 1'b1;
    sfp0 = 1'b0; efn0 = 1'b0;
    sfp1 = 1'b0; efn1 = 1'b0;
    step();
    step();
    chk("reset_u0", o0, '0);
    chk("reset_u1", o1, '0);
    reset = 1'b0;
    step();
    chk("idle_u0", o0, '0);

    // 1/2: full pass, next layer idle.
    kick0();
    run_loop(-1, -1, "t1");
    chk(tail[0].nm, o0, tail[0].exp);
    for (int i = 1; i < 7; i++) begin
      sfp0 = tail[i].sfp;
      efn0 = tail[i].efn;
      step();
      chk(tail[i].nm, o0, tail[i].exp);
    end
    sfp0 = 1'b0;
    efn0 = 1'b0;

    // 3: next busy -> stall; end_from_next lands with START (set wins).
    kick0();
    run_loop(-1, -1, "t3");
    drain_tail(5, 1'b1, "t3");

    // 4: two starts during RUN collapse into one pending start;
    //    next_busy still set from the START collision above.
    kick0();
    run_loop(60, 70, "t4a");
    drain_tail(3, 1'b0, "t4a");
    step();
    run_loop(-1, -1, "t4b");
    drain_tail(2, 1'b0, "t4b");
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t4_noqueue%0d", i), o0, '0);
    end

    // 5: reset at address 50 drops pending start and next_busy.
    kick0();
    for (int a = 0; a < 50; a++) begin
      chk($sformatf("t5_run%0d", a), o0, mk_run(a));
      sfp0 = (a == 40);
      step();
      sfp0 = 1'b0;
    end
    chk("t5_run50", o0, mk_run(50));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_rst", o0, '0);
    step();
    chk("t5_idle0", o0, '0);
    step();
    chk("t5_idle1", o0, '0);
    kick0();
    run_loop(-1, -1, "t5");
    drain_tail(0, 1'b0, "t5");

    // 6: FC2 depth with single-cycle drain.
    sfp1 = 1'b1;
    step();
    sfp1 = 1'b0;
    for (int a = 0; a < FC2_IFM_DEPTH; a++) begin
      chk($sformatf("t6_run%0d", a), o1, mk_run(a));
      step();
    end
    chk("t6_drain0", o1, mk_st(1, 1, 0, 0, 1));
    step();
    chk("t6_wait", o1, mk_st(0, 0, 0, 0, 1));
    step();
    chk("t6_handoff", o1, mk_st(0, 0, 1, 0, 1));
    step();
    chk("t6_start", o1, mk_st(0, 0, 0, 1, 1));
    step();
    chk("t6_idle", o1, '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
